// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, including the reserved
// opcode, and the controller state enum.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_MULU = 3'd5,
    ALU_DIVU = 3'd6,
    ALU_RSVD = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between a requester (master) and the ALU (slave).
interface alu_mc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
);
  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid && ready; valid never depends on ready; the sender holds payload
  // stable while valid is high and ready is low.
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] hi;
  logic                  zero;
  logic                  ovf;
  logic                  dz;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, hi, zero, ovf, dz
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, hi, zero, ovf, dz
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle. start loads operands; done is high during the last iteration cycle.
module alu_muldiv_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] res_lo,
  output logic [DATA_WIDTH-1:0] res_hi
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  logic                  busy_r;
  logic                  div_r;
  logic [CW-1:0]         cnt_r;
  logic [DATA_WIDTH-1:0] hi_r;   // product high word / partial remainder
  logic [DATA_WIDTH-1:0] lo_r;   // multiplier / dividend-quotient shifter
  logic [DATA_WIDTH-1:0] m_r;    // multiplicand or divisor

  logic [DATA_WIDTH:0]   add_s;
  logic [DATA_WIDTH:0]   shl;
  logic                  borrow;
  logic [DATA_WIDTH-1:0] nxt_hi;
  logic [DATA_WIDTH-1:0] nxt_lo;

  always_comb begin
    add_s  = '0;
    shl    = '0;
    borrow = 1'b0;
    nxt_hi = hi_r;
    nxt_lo = lo_r;
    if (div_r) begin
      // The remainder always fits DATA_WIDTH bits, so the wrapped difference is exact.
      shl    = {hi_r, lo_r[DATA_WIDTH-1]};
      borrow = (shl < {1'b0, m_r});
      nxt_hi = borrow ? shl[DATA_WIDTH-1:0] : (shl[DATA_WIDTH-1:0] - m_r);
      nxt_lo = {lo_r[DATA_WIDTH-2:0], ~borrow};
    end else begin
      add_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : '0);
      nxt_hi = add_s[DATA_WIDTH:1];
      nxt_lo = {add_s[0], lo_r[DATA_WIDTH-1:1]};
    end
  end

  assign done   = busy_r && (cnt_r == CW'(DATA_WIDTH - 1));
  assign res_lo = nxt_lo;
  assign res_hi = nxt_hi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      div_r  <= 1'b0;
      cnt_r  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      m_r    <= '0;
    end else if (start) begin
      busy_r <= 1'b1;
      div_r  <= is_div;
      cnt_r  <= '0;
      hi_r   <= '0;
      lo_r   <= is_div ? a : b;
      m_r    <= is_div ? b : a;
    end else if (busy_r) begin
      hi_r  <= nxt_hi;
      lo_r  <= nxt_lo;
      cnt_r <= cnt_r + CW'(1);
      if (done) busy_r <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU controller: single-cycle arithmetic/logic ops plus
// iterative MULU/DIVU through alu_muldiv_seq, with registered outputs.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_mc_if.slave ifc,
  output state_t dbg_state
);
  localparam int MSB = DATA_WIDTH - 1;

  state_t                state_r, state_nxt;
  op_t                   opc;
  logic [DATA_WIDTH-1:0] sum, diff;
  logic [DATA_WIDTH-1:0] res_c, hi_c;
  logic                  ovf_c, dz_c, go_seq;
  logic                  seq_start, load_single, load_seq;
  logic                  seq_done;
  logic [DATA_WIDTH-1:0] seq_lo, seq_hi;

  logic [DATA_WIDTH-1:0] result_r, hi_r;
  logic                  zero_r, ovf_r, dz_r;

  // Any opcode above 6 (including wider encodings) behaves as reserved.
  assign opc  = (ifc.op > OP_WIDTH'(6)) ? ALU_RSVD : op_t'(ifc.op[2:0]);
  assign sum  = ifc.a + ifc.b;
  assign diff = ifc.a - ifc.b;

  always_comb begin
    res_c  = '0;
    hi_c   = '0;
    ovf_c  = 1'b0;
    dz_c   = 1'b0;
    go_seq = 1'b0;
    case (opc)
      ALU_ADD: begin
        res_c = sum;
        ovf_c = (ifc.a[MSB] == ifc.b[MSB]) && (sum[MSB] != ifc.a[MSB]);
      end
      ALU_SUB: begin
        res_c = diff;
        ovf_c = (ifc.a[MSB] != ifc.b[MSB]) && (diff[MSB] != ifc.a[MSB]);
      end
      ALU_AND: res_c = ifc.a & ifc.b;
      ALU_OR:  res_c = ifc.a | ifc.b;
      ALU_SLT: res_c = {{(DATA_WIDTH-1){1'b0}}, ($signed(ifc.a) < $signed(ifc.b))};
      ALU_MULU: go_seq = 1'b1;
      ALU_DIVU: begin
        // Divide-by-zero resolves immediately instead of iterating.
        if (ifc.b == '0) begin
          res_c = '1;
          hi_c  = ifc.a;
          dz_c  = 1'b1;
        end else begin
          go_seq = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt   = state_r;
    seq_start   = 1'b0;
    load_single = 1'b0;
    load_seq    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ifc.in_valid) begin
          if (go_seq) begin
            seq_start = 1'b1;
            state_nxt = ST_BUSY;
          end else begin
            load_single = 1'b1;
            state_nxt   = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (seq_done) begin
          load_seq  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ifc.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      result_r <= '0;
      hi_r     <= '0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (load_single) begin
        result_r <= res_c;
        hi_r     <= hi_c;
        zero_r   <= (res_c == '0);
        ovf_r    <= ovf_c;
        dz_r     <= dz_c;
      end else if (load_seq) begin
        result_r <= seq_lo;
        hi_r     <= seq_hi;
        zero_r   <= (seq_lo == '0);
        ovf_r    <= 1'b0;
        dz_r     <= 1'b0;
      end
    end
  end

  alu_muldiv_seq #(.DATA_WIDTH(DATA_WIDTH)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (seq_start),
    .is_div (opc == ALU_DIVU),
    .a      (ifc.a),
    .b      (ifc.b),
    .done   (seq_done),
    .res_lo (seq_lo),
    .res_hi (seq_hi)
  );

  assign ifc.in_ready  = (state_r == ST_IDLE);
  assign ifc.out_valid = (state_r == ST_DONE);
  assign ifc.result    = result_r;
  assign ifc.hi        = hi_r;
  assign ifc.zero      = zero_r;
  assign ifc.ovf       = ovf_r;
  assign ifc.dz        = dz_r;
  assign dbg_state     = state_r;
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving operand/result width (legal 8..64, even).
REQ-002 The block SHALL have parameter OP_WIDTH, default 3, giving opcode width.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 op  input  OP_WIDTH  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 MULU, 6 DIVU, 7 reserved.
REQ-008 a, b  input  DATA_WIDTH each  operands.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  DATA_WIDTH  low product, quotient or logic/arith result.
REQ-012 hi  output  DATA_WIDTH  high product (MULU), remainder (DIVU), else 0.
REQ-013 zero, ovf, dz  output  1 each  result==0, signed overflow (ADD/SUB only), divide-by-zero (DIVU only).

Function
REQ-014 States SHALL be IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 IDLE: in_valid=1 SHALL register op, a, b; single-cycle ops (0-4, 7) go to DONE, MULU/DIVU go to BUSY.
REQ-016 Single-cycle op latency SHALL be 1: out_valid rises the cycle after acceptance.
REQ-017 MULU SHALL be iterative shift-add, one bit per cycle, DATA_WIDTH cycles in BUSY, then DONE; total latency DATA_WIDTH+1; {hi,result} = a*b unsigned, full 2*DATA_WIDTH.
REQ-018 DIVU SHALL be restoring division, one bit per cycle, same latency as MULU; result=a/b, hi=a%b unsigned.
REQ-019 DIVU with b=0 SHALL skip BUSY (latency 1), give result all-ones, hi=a, dz=1.
REQ-020 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; ovf=1 when operand signs match (ADD) / differ (SUB) and result sign differs from a.
REQ-021 SLT SHALL give result=1 if signed a<b else 0.
REQ-022 Reserved op 7 SHALL give result=0, hi=0, zero=1, ovf=0, dz=0.
REQ-023 zero SHALL equal (result==0) for every op, including MULU (low word only) and DIVU.
REQ-024 Flags not defined for an op SHALL be 0; hi SHALL be 0 for ops other than MULU/DIVU.
REQ-025 DONE SHALL hold result, hi and flags stable until out_valid&&out_ready, then go IDLE; no new request is accepted in that same cycle (one bubble).
REQ-026 in_valid in BUSY/DONE SHALL be ignored; a, b, op changes after acceptance SHALL not affect the result.
REQ-027 An iteration counter of width clog2(DATA_WIDTH)+1 SHALL count BUSY cycles and not wrap before the exit condition.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE and clear result, hi, zero, ovf, dz, out_valid and counter to 0; in_ready is 1 from the first cycle after reset.
REQ-029 Reset SHALL abort any BUSY or DONE operation immediately; the aborted result is never presented.
REQ-030 Reset has priority over every handshake event in the same cycle.

Structure
REQ-031 A package alu_pkg SHALL hold op encodings (ALU_ADD..ALU_DIVU), the state enum and the reserved-op constant.
REQ-032 The iterative multiply/divide datapath (accumulator, shift registers, counter) SHALL be one sub-module, alu_muldiv_seq, with start/done handshake; the FSM and single-cycle ops stay in alu_mc.

Verification (DATA_WIDTH=32)
REQ-033 ADD a=0x7FFFFFFF, b=1 -> 1 cycle later out_valid, result=0x80000000, ovf=1, zero=0; SUB a=5, b=5 -> result=0, zero=1, ovf=0.
REQ-034 MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid exactly 33 cycles after acceptance, hi=0xFFFFFFFE, result=0x00000001.
REQ-035 DIVU a=100, b=7 -> 33 cycles, result=14, hi=2; DIVU a=9, b=0 -> 1 cycle, result=0xFFFFFFFF, hi=9, dz=1.
REQ-036 Back-pressure: out_ready held 0 for 5 cycles after SLT a=-1, b=1 -> result=1 held stable, in_ready=0 throughout; in_valid pulsed meanwhile not accepted.
REQ-037 rst_n=0 on BUSY cycle 10 of MULU -> next cycle IDLE, outputs 0, out_valid never rises for that request; following ADD 2+3 returns 5.
REQ-038 Random regression: 10k random ops/operands with random valid/ready gaps vs reference model; every field matches, no lost or duplicated results.
